// File: rtl/fnd_display_controller.sv
// fnd_display_controller
// Scans a 4-digit common-anode 7-segment display one digit per scan tick.
// The time buses are snapshotted at the start of each frame, so the digits
// shown within a single frame always come from the same sample. The centre
// decimal point blinks at 1 Hz, driven by the msec field.

module fnd_display_controller #(
  parameter int COUNT_SCAN = 100_000,
  parameter int MSEC_MAX   = 100,
  parameter int SEC_MAX    = 60,
  parameter int MIN_MAX    = 60,
  parameter int HOUR_MAX   = 24
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [$clog2(MSEC_MAX)-1:0] i_msec,
  input  logic [$clog2(SEC_MAX)-1:0]  i_sec,
  input  logic [$clog2(MIN_MAX)-1:0]  i_min,
  input  logic [$clog2(HOUR_MAX)-1:0] i_hour,
  input  logic                        i_disp_mode,
  output logic [3:0]                  o_fnd_comm,
  output logic [7:0]                  o_fnd_font
);

  localparam int MSEC_W = $clog2(MSEC_MAX);
  localparam int SEC_W  = $clog2(SEC_MAX);
  localparam int MIN_W  = $clog2(MIN_MAX);
  localparam int HOUR_W = $clog2(HOUR_MAX);
  localparam int MS_W   = (MSEC_W > SEC_W) ? MSEC_W : SEC_W;
  localparam int MH_W   = (MIN_W > HOUR_W) ? MIN_W : HOUR_W;
  localparam int VAL_W  = (MS_W > MH_W) ? MS_W : MH_W;
  localparam int CNT_W  = (COUNT_SCAN > 1) ? $clog2(COUNT_SCAN) : 1;

  localparam logic [7:0] FONT_DASH  = 8'hBF;
  localparam logic [7:0] FONT_BLANK = 8'hFF;
  localparam logic [3:0] COMM_OFF   = 4'hF;

  // Segment pattern for one BCD digit, active-low, decimal point off.
  function automatic logic [7:0] seg_font(input logic [3:0] d);
    case (d)
      4'd0:    seg_font = 8'hC0;
      4'd1:    seg_font = 8'hF9;
      4'd2:    seg_font = 8'hA4;
      4'd3:    seg_font = 8'hB0;
      4'd4:    seg_font = 8'h99;
      4'd5:    seg_font = 8'h92;
      4'd6:    seg_font = 8'h82;
      4'd7:    seg_font = 8'hF8;
      4'd8:    seg_font = 8'h80;
      4'd9:    seg_font = 8'h90;
      default: seg_font = FONT_DASH;
    endcase
  endfunction

  logic [CNT_W-1:0]  scan_cnt_q,  scan_cnt_d;
  logic [1:0]        digit_idx_q, digit_idx_d;
  logic [MSEC_W-1:0] snap_msec_q, snap_msec_d;
  logic [SEC_W-1:0]  snap_sec_q,  snap_sec_d;
  logic [MIN_W-1:0]  snap_min_q,  snap_min_d;
  logic [HOUR_W-1:0] snap_hour_q, snap_hour_d;
  logic              snap_mode_q, snap_mode_d;
  logic [3:0]        comm_q,      comm_d;
  logic [7:0]        font_q,      font_d;

  logic              scan_tick;
  logic              snap_load;
  logic [VAL_W-1:0]  sel_val;
  logic [31:0]       sel_val32;
  logic [31:0]       sel_max;
  logic [3:0]        bcd;
  logic [7:0]        glyph;
  logic              dp_on;

  // Scan timing: slot counter, digit index and the frame-start snapshot.
  // The digit index names the slot that the next tick will display.
  // A snapshot is taken on the tick that displays digit0.
  always_comb begin
    scan_tick   = (scan_cnt_q == CNT_W'(COUNT_SCAN - 1));
    scan_cnt_d  = scan_tick ? '0 : scan_cnt_q + CNT_W'(1);
    digit_idx_d = scan_tick ? digit_idx_q + 2'd1 : digit_idx_q;
    snap_load   = scan_tick && (digit_idx_q == 2'd0);
    snap_msec_d = snap_load ? i_msec      : snap_msec_q;
    snap_sec_d  = snap_load ? i_sec       : snap_sec_q;
    snap_min_d  = snap_load ? i_min       : snap_min_q;
    snap_hour_d = snap_load ? i_hour      : snap_hour_q;
    snap_mode_d = snap_load ? i_disp_mode : snap_mode_q;
  end

  // Glyph for the slot being displayed. The glyph is built from the *_d
  // snapshot, so digit0 already uses the sample being captured on this tick.
  always_comb begin
    // NOTE: every combinational output is given a default first, so no path leaves it unassigned and no latch is inferred.
    sel_val = '0;
    sel_max = 32'(MSEC_MAX);
    case ({snap_mode_d, digit_idx_q[1]})
      2'b00: begin sel_val = VAL_W'(snap_msec_d); sel_max = 32'(MSEC_MAX); end
      2'b01: begin sel_val = VAL_W'(snap_sec_d);  sel_max = 32'(SEC_MAX);  end
      2'b10: begin sel_val = VAL_W'(snap_min_d);  sel_max = 32'(MIN_MAX);  end
      default: begin sel_val = VAL_W'(snap_hour_d); sel_max = 32'(HOUR_MAX); end
    endcase
    sel_val32 = 32'(sel_val);
    bcd       = digit_idx_q[0] ? 4'(sel_val32 / 32'd10) : 4'(sel_val32 % 32'd10);
    glyph     = (sel_val32 >= sel_max) ? FONT_DASH : seg_font(bcd);
    dp_on     = (digit_idx_q == 2'd2) && (32'(snap_msec_d) < 32'(MSEC_MAX / 2));
    font_d    = scan_tick ? {glyph[7] & ~dp_on, glyph[6:0]} : font_q;
    comm_d    = scan_tick ? ~(4'b0001 << digit_idx_q) : comm_q;
  end

  // State registers. The display stays blank until the first scan tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the snapshot is only a handful of flops, not a memory, so it is reset along with the rest; rendering from it is then defined from the first tick.
      scan_cnt_q  <= '0;
      digit_idx_q <= 2'd0;
      snap_msec_q <= '0;
      snap_sec_q  <= '0;
      snap_min_q  <= '0;
      snap_hour_q <= '0;
      snap_mode_q <= 1'b0;
      comm_q      <= COMM_OFF;
      font_q      <= FONT_BLANK;
    end else begin
      // NOTE: non-blocking assignments make every flop sample pre-edge values, so register order inside this block does not matter.
      scan_cnt_q  <= scan_cnt_d;
      digit_idx_q <= digit_idx_d;
      snap_msec_q <= snap_msec_d;
      snap_sec_q  <= snap_sec_d;
      snap_min_q  <= snap_min_d;
      snap_hour_q <= snap_hour_d;
      snap_mode_q <= snap_mode_d;
      comm_q      <= comm_d;
      font_q      <= font_d;
    end
  end

  assign o_fnd_comm = comm_q;
  assign o_fnd_font = font_q;

endmodule
